// File: rtl/dmem_responder.sv
// dmem_responder
//   Responder side of the MEM-stage data-memory interface for the 5-stage
//   MIPS pipeline. Accepts one word load or store per request, serves it
//   after LATENCY wait cycles and stalls MEM and upstream stages until the
//   response cycle.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words in the array (power of two)
//   LATENCY     : wait cycles between accept and response (0..15)
//
// Ports
//   CLK        : pipeline clock, rising edge
//   reset_n    : asynchronous active-low reset
//   req_valid  : MEM stage holds a load or store
//   req_we     : 1 = store, 0 = load
//   req_addr   : byte address
//   req_wdata  : store data
//   mem_stall  : combinational stall to the hazard unit
//   resp_valid : one-cycle response strobe
//   resp_rdata : load data (0 for stores and misaligned accesses)
//   resp_err   : misaligned access flag, valid with resp_valid
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned AW    = IDX_W + 2;
  localparam logic [3:0]  LAT4  = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

  stateT          state;
  logic [3:0]     waitCnt;
  logic           latWe;
  logic [AW-1:0]  latAddr;
  logic [31:0]    latWdata;
  logic [31:0]    memArray [DEPTH_WORDS];

  logic           accFire;
  logic           accWe;
  logic           accMis;
  logic [AW-1:0]  accAddr;
  logic [31:0]    accWdata;
  logic [IDX_W-1:0] accIdx;

  // Address bits above the array wrap are intentionally ignored.
  logic unusedAddrHi;
  assign unusedAddrHi = ^req_addr[31:AW];

  // With zero latency the access happens on the accept edge, so the live
  // request fields are used instead of the (not yet loaded) latched copies.
  always_comb begin
    accWe    = latWe;
    accAddr  = latAddr;
    accWdata = latWdata;
    accFire  = 1'b0;
    if (state == IDLE) begin
      accWe    = req_we;
      accAddr  = req_addr[AW-1:0];
      accWdata = req_wdata;
      accFire  = req_valid && (LATENCY == 0);
    end else if (state == WAIT) begin
      accFire  = (waitCnt == 4'd1);
    end
    // A store still pending while reset is held must never reach the array.
    accFire = accFire && reset_n;
  end

  assign accIdx = accAddr[AW-1:2];
  assign accMis = |accAddr[1:0];

  // Array has no reset so contents survive a pipeline reset.
  always_ff @(posedge CLK) begin
    if (accFire && accWe && !accMis) begin
      memArray[accIdx] <= accWdata;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      waitCnt    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      latWe      <= 1'b0;
      latAddr    <= '0;
      latWdata   <= '0;
    end else begin
      resp_valid <= 1'b0;

      if (accFire) begin
        resp_err   <= accMis;
        resp_rdata <= (accWe || accMis) ? '0 : memArray[accIdx];
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            latWe    <= req_we;
            latAddr  <= req_addr[AW-1:0];
            latWdata <= req_wdata;
            waitCnt  <= LAT4;
            if (LATENCY > 0) begin
              state <= WAIT;
            end else begin
              state      <= DONE;
              resp_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt == 4'd1) begin
            state      <= DONE;
            resp_valid <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_stall = req_valid && (state != DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Three responders (LATENCY 2, 0, 3) on one clock and reset. Each request
//   is checked cycle by cycle for stall and response timing, and response
//   data/err against a word-array model indexed by (addr mod 1024) / 4.
module tb_dmem_responder;

  localparam int NDUT = 3;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        reqValid  [NDUT];
  logic        reqWe     [NDUT];
  logic [31:0] reqAddr   [NDUT];
  logic [31:0] reqWdata  [NDUT];
  logic        memStall  [NDUT];
  logic        respValid [NDUT];
  logic [31:0] respRdata [NDUT];
  logic        respErr   [NDUT];

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl   [NDUT][256];
  bit          known [NDUT][256];

  always #5 CLK = ~CLK;

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(256),
      .LATENCY((i == 0) ? 2 : ((i == 1) ? 0 : 3))
    ) u_dut (
      .CLK       (CLK),
      .reset_n   (reset_n),
      .req_valid (reqValid[i]),
      .req_we    (reqWe[i]),
      .req_addr  (reqAddr[i]),
      .req_wdata (reqWdata[i]),
      .mem_stall (memStall[i]),
      .resp_valid(respValid[i]),
      .resp_rdata(respRdata[i]),
      .resp_err  (respErr[i])
    );
  end

  function automatic int latOf(input logic [1:0] k);
    return (k == 2'd0) ? 2 : ((k == 2'd1) ? 0 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One request from accept to response. dropAt: cycle index at which
  // req_valid is pulled low (-1 = never). scramble: randomise req_* after
  // the accept edge; the responder must keep using the latched request.
  task automatic txn(input logic [1:0] k, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit scramble, input int dropAt);
    int          lat;
    logic [7:0]  idx;
    bit          mis;
    logic [31:0] expData;
    bit          chkData;
    lat     = latOf(k);
    idx     = 8'((addr % 32'd1024) / 32'd4);
    mis     = (addr % 32'd4) != 32'd0;
    expData = '0;
    chkData = 1'b1;
    if (!mis) begin
      if (we) begin
        mdl[k][idx]   = wdata;
        known[k][idx] = 1'b1;
      end else if (known[k][idx]) begin
        expData = mdl[k][idx];
      end else begin
        chkData = 1'b0;
      end
    end
    @(negedge CLK);
    reqValid[k] = 1'b1;
    reqWe[k]    = we;
    reqAddr[k]  = addr;
    reqWdata[k] = wdata;
    #1;
    for (int c = 0; c <= lat + 1; c++) begin
      if (c > 0) begin
        @(negedge CLK);
        if (c == dropAt) reqValid[k] = 1'b0;
        if (scramble) begin
          reqWe[k]    = 1'($urandom);
          reqAddr[k]  = $urandom;
          reqWdata[k] = $urandom;
        end
        #1;
      end
      check($sformatf("dut%0d a=%h c%0d stall", k, addr, c), 32'(memStall[k]),
            32'(reqValid[k] && (c <= lat)));
      check($sformatf("dut%0d a=%h c%0d resp_valid", k, addr, c), 32'(respValid[k]),
            32'(c == lat + 1));
      if (c == lat + 1) begin
        check($sformatf("dut%0d a=%h resp_err", k, addr), 32'(respErr[k]), 32'(mis));
        if (chkData)
          check($sformatf("dut%0d a=%h resp_rdata", k, addr), respRdata[k], expData);
      end
    end
  endtask

  task automatic idle(input logic [1:0] k);
    @(negedge CLK);
    reqValid[k] = 1'b0;
    #1;
    check($sformatf("dut%0d idle stall", k), 32'(memStall[k]), 32'd0);
    check($sformatf("dut%0d idle resp_valid", k), 32'(respValid[k]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int k = 0; k < NDUT; k++) begin
      reqValid[k] = 1'b0;
      reqWe[k]    = 1'b0;
      reqAddr[k]  = '0;
      reqWdata[k] = '0;
    end
    repeat (2) @(negedge CLK);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("dut%0d reset resp_valid", k), 32'(respValid[k]), 32'd0);
      check($sformatf("dut%0d reset resp_rdata", k), respRdata[k], 32'd0);
      check($sformatf("dut%0d reset resp_err", k), 32'(respErr[k]), 32'd0);
      check($sformatf("dut%0d reset stall", k), 32'(memStall[k]), 32'd0);
    end
    reset_n = 1'b1;

    // LATENCY = 2: basic, back-to-back, misaligned, wrap
    txn(2'd0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, -1);
    txn(2'd0, 1'b0, 32'h0000_0008, 32'h0,         1'b0, -1);
    txn(2'd0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, -1);
    txn(2'd0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, -1);
    txn(2'd0, 1'b1, 32'h0000_0004, 32'h0BAD_F00D, 1'b0, -1);
    txn(2'd0, 1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 1'b0, -1);
    txn(2'd0, 1'b0, 32'h0000_0004, 32'h0,         1'b0, -1);
    txn(2'd0, 1'b1, 32'h0000_0404, 32'hA5A5_A5A5, 1'b0, -1);
    txn(2'd0, 1'b0, 32'h0000_0004, 32'h0,         1'b0, -1);
    txn(2'd0, 1'b1, 32'h0000_0020, 32'h0,         1'b0, -1);
    idle(2'd0);

    // Reset during WAIT of a store: store must not commit
    @(negedge CLK);
    reqValid[0] = 1'b1;
    reqWe[0]    = 1'b1;
    reqAddr[0]  = 32'h0000_0020;
    reqWdata[0] = 32'h5555_5555;
    #1;
    check("abort accept stall", 32'(memStall[0]), 32'd1);
    @(negedge CLK);
    #1;
    check("abort wait stall", 32'(memStall[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    reqValid[0] = 1'b0;
    check("abort resp_valid", 32'(respValid[0]), 32'd0);
    check("abort resp_rdata", respRdata[0], 32'd0);
    repeat (2) begin
      @(negedge CLK);
      #1;
      check("abort held resp_valid", 32'(respValid[0]), 32'd0);
    end
    reset_n = 1'b1;
    txn(2'd0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, -1);
    idle(2'd0);

    // LATENCY = 0
    txn(2'd1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 1'b0, -1);
    txn(2'd1, 1'b0, 32'h0000_0030, 32'h0,         1'b0, -1);
    txn(2'd1, 1'b0, 32'h0000_0031, 32'h0,         1'b0, -1);
    idle(2'd1);

    // LATENCY = 3: req_valid dropped mid-WAIT, inputs changed mid-WAIT
    txn(2'd2, 1'b1, 32'h0000_0040, 32'h0F0F_0F0F, 1'b0, -1);
    txn(2'd2, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 2);
    txn(2'd2, 1'b1, 32'h0000_0044, 32'h7777_1111, 1'b1, 1);
    txn(2'd2, 1'b0, 32'h0000_0044, 32'h0,         1'b1, -1);
    idle(2'd2);

    // Random traffic on each responder
    for (int k = 0; k < NDUT; k++) begin
      for (int n = 0; n < 40; n++) begin
        a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2);
        if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
        txn(2'(k), 1'($urandom), a, $urandom, 1'b1,
            ($urandom_range(0, 4) == 0) ? 1 : -1);
        repeat ($urandom_range(0, 2)) idle(2'(k));
      end
      idle(2'(k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
